wb_initiator: RTL
=================

Name: wb_initiator

Overview:
- Wishbone classic single-transfer master; drives the user-area Wishbone slave interface from a simple command/response port.
- Command port is fed from logic-analyzer probes or a test controller.
- Lets the management side or a bench exercise the slave without the SoC CPU.
- Sits beside the user project inside the wrapper, on the same wb_clk_i domain.

Parameters:
- TIMEOUT_CYCLES, 255, number of cycles waiting for ack/err before the transfer is aborted with error; legal range 1..2^CNT_W-1.
- CNT_W, 8, timeout counter width.

Ports:
- wb_clk_i  in  1  Wishbone clock; single clock domain.
- wb_rst_i  in  1  synchronous reset, active-low; sampled on rising wb_clk_i.
- cmd_valid_i  in  1  command request.
- cmd_ready_o  out  1  command accepted when valid & ready.
- cmd_we_i  in  1  1 = write, 0 = read.
- cmd_adr_i  in  32  byte address.
- cmd_dat_i  in  32  write data.
- cmd_sel_i  in  4  byte selects.
- rsp_valid_o  out  1  response available.
- rsp_ready_i  in  1  response consumed when valid & ready.
- rsp_dat_o  out  32  read data; 0 for writes and errors.
- rsp_err_o  out  1  1 = bus err or timeout.
- rsp_tmo_o  out  1  1 = timeout (implies rsp_err_o).
- wbm_cyc_o  out  1  Wishbone cycle.
- wbm_stb_o  out  1  Wishbone strobe.
- wbm_we_o  out  1  write enable.
- wbm_adr_o  out  32  address.
- wbm_dat_o  out  32  write data.
- wbm_sel_o  out  4  byte selects.
- wbm_ack_i  in  1  slave acknowledge.
- wbm_err_i  in  1  slave error.
- wbm_dat_i  in  32  read data.

Behaviour:
- Reset (wb_rst_i low at a clock edge) forces state IDLE and clears the timeout counter.
- Reset values: all outputs 0, except cmd_ready_o = 1 from the first cycle after reset.
- Reset mid-transfer: cyc/stb drop after that edge; any pending response is discarded.
- FSM states: IDLE, BUS, RESP.
- IDLE:
  - cmd_ready_o = 1.
  - On valid & ready at edge N: register we/adr/dat/sel onto the wbm_* outputs and go to BUS.
  - wbm_cyc_o = wbm_stb_o = 1 from cycle N+1.
- BUS:
  - cmd_ready_o = 0; cyc/stb/we/adr/dat/sel held stable.
  - Counter increments each cycle in BUS.
  - Priority at each edge, highest first: err_i, then ack_i, then counter == TIMEOUT_CYCLES-1.
  - err_i: rsp_err_o = 1, rsp_dat_o = 0.
  - ack_i: rsp_err_o = 0; rsp_dat_o = wbm_dat_i for reads, 0 for writes.
  - Timeout: rsp_err_o = 1, rsp_tmo_o = 1, rsp_dat_o = 0.
  - Any of the three: cyc/stb deassert, go to RESP, rsp_valid_o = 1 next cycle, counter cleared.
  - ack_i on the same edge the counter reaches its limit: ack wins.
- RESP:
  - rsp_valid_o and rsp_* held stable until rsp_ready_i.
  - On valid & ready: rsp_valid_o = 0, go to IDLE.
  - cmd_ready_o = 1 from the following cycle; no overlap of command and response.
- Latency: accept at edge N, zero-wait slave acks at edge N+1, rsp_valid_o high from N+2.
- Minimum cyc pulse is 1 cycle; back-to-back transfers have cyc low for ≥2 cycles.
- ack_i/err_i outside BUS are ignored.
- wbm_we_o/adr/dat/sel keep their last values when idle; only cyc/stb are guaranteed low.
- Timeout counter saturates; no wrap.

Decomposition:
- Shared package wb_pkg:
  - WB_ADR_W = 32, WB_DAT_W = 32, WB_SEL_W = 4.
  - State enum wb_init_state_t {IDLE, BUS, RESP}.
  - Response struct {dat, err, tmo}.
- One sub-module: wb_timeout_ctr.
  - Inputs: clear, enable.
  - Output: expired, combinational on count == TIMEOUT_CYCLES-1.
  - Parameterised by TIMEOUT_CYCLES/CNT_W.

Test Plan:
- Write 0xCAFE_0001 to 0x3000_0000, sel = 0xF, slave acks after 2 wait states:
  - cyc/stb high exactly 3 cycles with stable adr/dat/sel/we = 1.
  - rsp_valid_o with err = 0, dat = 0.
- Read 0x3000_0004, zero-wait slave returns 0x1234_5678:
  - rsp_dat_o = 0x1234_5678 two cycles after accept.
- Non-responding slave, TIMEOUT_CYCLES = 4:
  - cyc high 4 cycles then drops.
  - rsp_err_o = 1, rsp_tmo_o = 1, rsp_dat_o = 0.
- Slave asserts ack and err together on a read:
  - rsp_err_o = 1, rsp_tmo_o = 0, rsp_dat_o = 0.
- Hold rsp_ready_i low 5 cycles while cmd_valid_i is high:
  - response stable; cmd_ready_o stays 0 until 1 cycle after rsp handshake; next command issued.
- Assert wb_rst_i low in the 2nd BUS cycle:
  - cyc/stb 0 after that edge; rsp_valid_o stays 0; cmd_ready_o = 1 after release.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and widths for the Wishbone single-transfer initiator.
//   WB_ADR_W/WB_DAT_W/WB_SEL_W : bus field widths
//   wb_init_state_t            : initiator FSM state encoding
//   wb_rsp_t                   : registered response (read data, error, timeout)
package wb_pkg;

  localparam int WB_ADR_W = 32;
  localparam int WB_DAT_W = 32;
  localparam int WB_SEL_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } wb_init_state_t;

  typedef struct packed {
    logic [WB_DAT_W-1:0] dat;
    logic                err;
    logic                tmo;
  } wb_rsp_t;

endpackage

// File: rtl/wb_timeout_ctr.sv
// Saturating up-counter that flags when a bus transfer has waited too long.
//   i_clk     : clock
//   i_rst_n   : synchronous active-low reset
//   i_clear   : zero the count (wins over i_enable)
//   i_enable  : count one cycle
//   o_expired : combinational, high while count == TIMEOUT_CYCLES-1
module wb_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam logic [CNT_W-1:0] LP_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] LP_MAX   = '1;

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != LP_MAX)) begin
      // Hold at all-ones rather than wrapping back to zero.
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expired = (r_count == LP_LIMIT);

endmodule

// File: rtl/wb_initiator.sv
// Wishbone classic single-transfer master driven by a command/response port.
//   wb_clk_i, wb_rst_i (sync, active-low)
//   cmd_* : command in (valid/ready handshake, we/adr/dat/sel)
//   rsp_* : response out (valid/ready handshake, dat/err/tmo)
//   wbm_* : Wishbone master interface to the user-area slave
//
//   state | meaning
//   IDLE  | ready for a command, cyc/stb low
//   BUS   | cyc/stb high, waiting for err/ack or timeout
//   RESP  | response presented, waiting for rsp_ready_i
module wb_initiator
  import wb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,

  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic                cmd_we_i,
  input  logic [WB_ADR_W-1:0] cmd_adr_i,
  input  logic [WB_DAT_W-1:0] cmd_dat_i,
  input  logic [WB_SEL_W-1:0] cmd_sel_i,

  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [WB_DAT_W-1:0] rsp_dat_o,
  output logic                rsp_err_o,
  output logic                rsp_tmo_o,

  output logic                wbm_cyc_o,
  output logic                wbm_stb_o,
  output logic                wbm_we_o,
  output logic [WB_ADR_W-1:0] wbm_adr_o,
  output logic [WB_DAT_W-1:0] wbm_dat_o,
  output logic [WB_SEL_W-1:0] wbm_sel_o,
  input  logic                wbm_ack_i,
  input  logic                wbm_err_i,
  input  logic [WB_DAT_W-1:0] wbm_dat_i
);

  wb_init_state_t r_state;
  wb_init_state_t w_state_nxt;

  logic                r_we;
  logic [WB_ADR_W-1:0] r_adr;
  logic [WB_DAT_W-1:0] r_dat;
  logic [WB_SEL_W-1:0] r_sel;
  wb_rsp_t             r_rsp;

  logic    w_cmd_load;
  logic    w_rsp_load;
  wb_rsp_t w_rsp_nxt;
  logic    w_cmd_ready;
  logic    w_bus_active;
  logic    w_rsp_valid;
  logic    w_expired;

  wb_timeout_ctr #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_timeout_ctr (
    .i_clk     (wb_clk_i),
    .i_rst_n   (wb_rst_i),
    .i_clear   (~w_bus_active | w_rsp_load),
    .i_enable  (w_bus_active),
    .o_expired (w_expired)
  );

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cmd_load   = 1'b0;
    w_rsp_load   = 1'b0;
    w_rsp_nxt    = '0;
    w_cmd_ready  = 1'b0;
    w_bus_active = 1'b0;
    w_rsp_valid  = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_cmd_ready = 1'b1;
        if (cmd_valid_i) begin
          w_cmd_load  = 1'b1;
          w_state_nxt = BUS;
        end
      end
      BUS: begin
        w_bus_active = 1'b1;
        // err beats ack, and ack beats a timeout landing on the same edge.
        if (wbm_err_i) begin
          w_rsp_load    = 1'b1;
          w_rsp_nxt.err = 1'b1;
        end else if (wbm_ack_i) begin
          w_rsp_load    = 1'b1;
          w_rsp_nxt.dat = r_we ? '0 : wbm_dat_i;
        end else if (w_expired) begin
          w_rsp_load    = 1'b1;
          w_rsp_nxt.err = 1'b1;
          w_rsp_nxt.tmo = 1'b1;
        end
        if (w_rsp_load) begin
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        w_rsp_valid = 1'b1;
        if (rsp_ready_i) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Bus fields are only reloaded on accept, so they keep their last value while idle.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      r_we  <= 1'b0;
      r_adr <= '0;
      r_dat <= '0;
      r_sel <= '0;
    end else if (w_cmd_load) begin
      r_we  <= cmd_we_i;
      r_adr <= cmd_adr_i;
      r_dat <= cmd_dat_i;
      r_sel <= cmd_sel_i;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      r_rsp <= '0;
    end else if (w_rsp_load) begin
      r_rsp <= w_rsp_nxt;
    end
  end

  assign cmd_ready_o = w_cmd_ready;
  assign rsp_valid_o = w_rsp_valid;
  assign rsp_dat_o   = r_rsp.dat;
  assign rsp_err_o   = r_rsp.err;
  assign rsp_tmo_o   = r_rsp.tmo;
  assign wbm_cyc_o   = w_bus_active;
  assign wbm_stb_o   = w_bus_active;
  assign wbm_we_o    = r_we;
  assign wbm_adr_o   = r_adr;
  assign wbm_dat_o   = r_dat;
  assign wbm_sel_o   = r_sel;

endmodule
